// File: rtl/eth_mac_tx_ptp_ts_pkg.sv
// eth_mac_tx_ptp_ts_pkg: shared tuser bit layout and default widths for the TX/RX PTP timestamp blocks
package eth_mac_tx_ptp_ts_pkg;
  localparam int USER_BAD_BIT = 0;
  localparam int USER_TAG_LSB = 1;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_PTP_TS_WIDTH = 96;
  localparam int DEF_PTP_TAG_WIDTH = 16;
  localparam int DEF_TS_FIFO_DEPTH = 4;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/eth_ptp_ts_fifo.sv
// eth_ptp_ts_fifo: valid/ready timestamp FIFO that drops new entries when full and not popping
module eth_ptp_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 112
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic empty, full, pop, wr_en;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop = !empty && pop_ready;
    wr_en = push && (!full || pop);
    drop = push && full && !pop;
    wr_d = wr_en ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
  end
  assign head_valid = !empty;
  assign head_data = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/eth_mac_tx_ptp_ts.sv
// eth_mac_tx_ptp_ts: TX skid buffer that timestamps each frame at SOF and commits the stamp on a good EOF
module eth_mac_tx_ptp_ts
  import eth_mac_tx_ptp_ts_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int PTP_TS_WIDTH = DEF_PTP_TS_WIDTH,
  parameter int PTP_TAG_WIDTH = DEF_PTP_TAG_WIDTH,
  parameter int TS_FIFO_DEPTH = DEF_TS_FIFO_DEPTH,
  parameter int USER_WIDTH = PTP_TAG_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [PTP_TS_WIDTH-1:0]  ptp_time,
  output logic [PTP_TS_WIDTH-1:0]  m_axis_ts,
  output logic [PTP_TAG_WIDTH-1:0] m_axis_ts_tag,
  output logic                     m_axis_ts_valid,
  input  logic                     m_axis_ts_ready,
  output logic                     ts_drop,
  output logic [15:0]              drop_count
);
  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam int FW = PTP_TS_WIDTH + PTP_TAG_WIDTH;
  logic m_valid_q, m_valid_d, skid_valid_q, skid_valid_d, sof_q, sof_d, ts_drop_q, ts_drop_d;
  logic [BW-1:0] m_data_q, m_data_d, skid_q, skid_d, in_beat;
  logic [FW-1:0] pend_q, pend_d, cur_entry, push_data;
  logic [15:0] drop_count_q, drop_count_d;
  logic accept, load, push, fifo_drop;
  assign s_axis_tready = !skid_valid_q && !rst;
  always_comb begin
    in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    accept = s_axis_tvalid && s_axis_tready;
    load = !m_valid_q || m_axis_tready;
    m_valid_d = load ? (skid_valid_q || accept) : m_valid_q;
    m_data_d = load ? (skid_valid_q ? skid_q : in_beat) : m_data_q;
    skid_valid_d = load ? 1'b0 : (skid_valid_q || accept);
    skid_d = (!load && accept) ? in_beat : skid_q;
    cur_entry = {ptp_time, s_axis_tuser[USER_TAG_LSB +: PTP_TAG_WIDTH]};
    sof_d = accept ? s_axis_tlast : sof_q;
    pend_d = (accept && sof_q) ? cur_entry : pend_q;
    push = accept && s_axis_tlast && !s_axis_tuser[USER_BAD_BIT];
    // a single-beat frame commits the stamp taken on that very beat
    push_data = sof_q ? cur_entry : pend_q;
    ts_drop_d = fifo_drop;
    drop_count_d = fifo_drop ? sat_inc16(drop_count_q) : drop_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      sof_q <= 1'b1;
      ts_drop_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      skid_valid_q <= skid_valid_d;
      sof_q <= sof_d;
      ts_drop_q <= ts_drop_d;
      drop_count_q <= drop_count_d;
    end
  end
  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
    skid_q <= skid_d;
    pend_q <= pend_d;
  end
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign ts_drop = ts_drop_q;
  assign drop_count = drop_count_q;
  eth_ptp_ts_fifo #(.DEPTH(TS_FIFO_DEPTH), .WIDTH(FW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(push_data),
    .pop_ready(m_axis_ts_ready),
    .head_data({m_axis_ts, m_axis_ts_tag}),
    .head_valid(m_axis_ts_valid),
    .drop(fifo_drop)
  );
endmodule

// File: tb/tb_eth_mac_tx_ptp_ts.sv
// tb_eth_mac_tx_ptp_ts: scoreboard bench for the TX PTP timestamp block
module tb_eth_mac_tx_ptp_ts;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TSW = 96;
  localparam int TGW = 16;
  localparam int UW = TGW + 1;
  localparam int DEPTH = 4;
  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    logic [UW-1:0] u;
  } beat_t;
  typedef struct {
    logic [TSW-1:0] ts;
    logic [TGW-1:0] tag;
  } ts_t;
  logic clk, rst;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic s_tlast, m_tlast, s_tvalid, s_tready, m_tvalid, m_tready;
  logic [UW-1:0] s_tuser, m_tuser;
  logic [TSW-1:0] ptp_time, m_ts;
  logic [TGW-1:0] m_ts_tag;
  logic ts_valid, ts_ready, ts_drop;
  logic [15:0] drop_count;
  int n_chk = 0;
  int n_pass = 0;
  bit rnd = 0;
  beat_t bq[$];
  ts_t tsq[$];
  bit m_sof = 1;
  ts_t m_pend;
  bit exp_drop = 0;
  logic [15:0] exp_cnt = 0;
  bit was_rst = 0;
  eth_mac_tx_ptp_ts dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .ptp_time(ptp_time), .m_axis_ts(m_ts), .m_axis_ts_tag(m_ts_tag),
    .m_axis_ts_valid(ts_valid), .m_axis_ts_ready(ts_ready),
    .ts_drop(ts_drop), .drop_count(drop_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    ptp_time = 96'd1000;
    forever begin
      @(posedge clk);
      #1 ptp_time = ptp_time + 96'd3;
    end
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    ts_t e, cur;
    beat_t b;
    if (rst) begin
      chk("tready_in_rst", 128'(s_tready), 128'(0));
      bq.delete();
      tsq.delete();
      m_sof = 1;
      exp_drop = 0;
      exp_cnt = 0;
      was_rst = 1;
    end else begin
      if (was_rst) chk("tready_after_rst", 128'(s_tready), 128'(1));
      was_rst = 0;
      chk("ts_drop", 128'(ts_drop), 128'(exp_drop));
      chk("drop_count", 128'(drop_count), 128'(exp_cnt));
      chk("ts_valid", 128'(ts_valid), 128'(tsq.size() != 0));
      if (ts_valid && ts_ready && tsq.size() != 0) begin
        e = tsq.pop_front();
        chk("ts_value", 128'(m_ts), 128'(e.ts));
        chk("ts_tag", 128'(m_ts_tag), 128'(e.tag));
      end
      if (m_tvalid && m_tready) begin
        chk("beat_avail", 128'(bq.size() != 0), 128'(1));
        if (bq.size() != 0) begin
          b = bq.pop_front();
          chk("tdata", 128'(m_tdata), 128'(b.d));
          chk("tkeep_last_user", 128'({m_tkeep, m_tlast, m_tuser}), 128'({b.k, b.l, b.u}));
        end
      end
      exp_drop = 0;
      if (s_tvalid && s_tready) begin
        bq.push_back('{s_tdata, s_tkeep, s_tlast, s_tuser});
        cur = '{ptp_time, s_tuser[TGW:1]};
        if (!m_sof) cur = m_pend;
        m_pend = cur;
        if (s_tlast && !s_tuser[0]) begin
          if (tsq.size() < DEPTH) tsq.push_back(cur);
          else begin
            exp_drop = 1;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          end
        end
        m_sof = s_tlast;
      end
    end
  end
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        m_tready = 1'($urandom_range(1));
        ts_ready = 1'($urandom_range(1));
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [UW-1:0] u, input bit pop_too);
    bit acc = 0;
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    s_tuser = u;
    for (int i = 0; i < 1000 && !acc; i++) begin
      if (rnd) begin
        m_tready = 1'($urandom_range(1));
        ts_ready = 1'($urandom_range(1));
        s_tvalid = 1'($urandom_range(1));
      end else s_tvalid = 1;
      if (pop_too) ts_ready = 1;
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
    end
    s_tvalid = 0;
    if (pop_too) ts_ready = 0;
    if (!acc) chk("send_timeout", 128'(acc), 128'(1));
  endtask
  task automatic send_frame(input int n, input bit bad, input bit pop_last);
    logic [TGW-1:0] tag;
    tag = 16'($urandom);
    for (int i = 0; i < n; i++)
      send_beat({$urandom, $urandom}, 8'($urandom), i == n - 1,
                {tag, (i == n - 1) ? bad : 1'($urandom_range(1))}, pop_last && i == n - 1);
  endtask
  initial begin
    logic [DW-1:0] d0;
    rst = 1;
    s_tvalid = 0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = 0;
    s_tuser = '0;
    m_tready = 1;
    ts_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(1);
    d0 = {$urandom, $urandom};
    send_beat(d0, 8'hFF, 1, {16'h0ABC, 1'b0}, 0);
    chk("lat1_tvalid", 128'(m_tvalid), 128'(1));
    chk("lat1_tdata", 128'(m_tdata), 128'(d0));
    idle(3);
    send_frame(3, 1, 0);
    idle(3);
    ts_ready = 0;
    repeat (5) send_frame(1, 0, 0);
    idle(3);
    chk("drop_cnt_after5", 128'(drop_count), 128'(1));
    send_frame(2, 0, 1);
    idle(3);
    chk("drop_cnt_push_pop_full", 128'(drop_count), 128'(1));
    ts_ready = 1;
    idle(8);
    send_beat({$urandom, $urandom}, 8'hFF, 0, 17'h00010, 0);
    send_beat({$urandom, $urandom}, 8'hFF, 0, 17'h00010, 0);
    rst = 1;
    idle(2);
    rst = 0;
    idle(1);
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_ts_valid", 128'(ts_valid), 128'(0));
    send_frame(1, 0, 0);
    idle(3);
    rnd = 1;
    for (int f = 0; f < 1000; f++) begin
      send_frame($urandom_range(1, 4), $urandom_range(9) == 0, 0);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
    rnd = 0;
    m_tready = 1;
    ts_ready = 1;
    for (int i = 0; i < 2000 && (bq.size() != 0 || tsq.size() != 0); i++) idle(1);
    chk("beats_left", 128'(bq.size()), 128'(0));
    chk("ts_left", 128'(tsq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
